iserdes_e2: RTL and testbench

Single-clock input deserializer that converts a serial bit stream on `D` into parallel words of `DATA_WIDTH` bits on `Q1..Q8`. It supports SDR and DDR capture, and bitslip-based word alignment. It sits directly behind the receive pad in the RX recovery path and feeds the word-alignment and decode logic. A combinational pass-through `O` lets alignment logic watch the raw stream.

---
 rtl/iserdes_e2_if.sv | 29 ++
 rtl/iserdes_e2.sv | 122 ++++++++++++
 tb/tb_iserdes_e2.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iserdes_e2_if.sv
// rtl/iserdes_e2_if.sv - serial input, enables, bitslip and parallel word bundle for iserdes_e2
interface iserdes_e2_if;
    logic D;
    logic DDLY;
    logic CE1;
    logic CE2;
    logic BITSLIP;
    logic O;
    logic Q1;
    logic Q2;
    logic Q3;
    logic Q4;
    logic Q5;
    logic Q6;
    logic Q7;
    logic Q8;

    // Pad/alignment side: drives the serial stream and controls, watches the words.
    modport master (
        output D, DDLY, CE1, CE2, BITSLIP,
        input  O, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8
    );

    // Deserializer side.
    modport slave (
        input  D, DDLY, CE1, CE2, BITSLIP,
        output O, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8
    );
endinterface

// File: rtl/iserdes_e2.sv
// rtl/iserdes_e2.sv - SDR/DDR input deserializer with bitslip word alignment
module iserdes_e2 #(
    parameter     DATA_RATE      = "DDR",
    parameter int DATA_WIDTH     = 8,
    parameter     INTERFACE_TYPE = "NETWORKING"
) (
    input logic         CLK,
    input logic         RST,
    iserdes_e2_if.slave io
);
    // Bits captured per rising edge, rising edges per word, shift register width.
    localparam int         B    = (DATA_RATE == "SDR") ? 1 : 2;
    localparam int         K    = DATA_WIDTH / B;
    localparam int         SW   = DATA_WIDTH + B;
    localparam logic [3:0] LAST = 4'(K - 1);

    logic                  ce;
    logic                  fall_q;
    logic [SW-1:0]         shift_q;
    logic [SW-1:0]         shift_d;
    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;
    logic                  off_q;
    logic                  off_d;
    logic                  stall_q;
    logic                  stall_d;
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] window;
    logic                  boundary;
    logic [7:0]            q_ext;
    logic                  unused_sink;

    assign io.O = io.D;
    assign ce   = io.CE1 & io.CE2;

    // DDLY, the interface type and the shift register's spare upper bits carry no logic.
    assign unused_sink = &{1'b0, io.DDLY, fall_q, shift_q, (INTERFACE_TYPE == "NETWORKING")};

    // Falling-edge sample of D: the older of the two bits in a DDR cycle.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= io.D;
        end
    end

    // Newest bit lands in bit 0; in DDR the falling-edge sample goes in just above it.
    always_comb begin
        shift_d = shift_q;
        if (B == 2) begin
            shift_d = {shift_q[SW-3:0], fall_q, io.D};
        end else begin
            shift_d = {shift_q[SW-2:0], io.D};
        end
    end

    // With the offset bit set the word ends one bit before the newest captured bit.
    assign window   = off_q ? shift_d[DATA_WIDTH:1] : shift_d[DATA_WIDTH-1:0];
    assign boundary = (cnt_q == LAST) && !stall_q;

    // Word counter, slip bookkeeping and output load.
    // A DDR slip that sets the offset bit also stalls the counter one cycle: the boundary
    // moves two bits later and the window one bit earlier, netting one bit later. The next
    // slip clears the offset bit (window one bit later) without a stall. After DATA_WIDTH
    // slips the boundary has moved exactly one word. In SDR every slip is one stall.
    always_comb begin
        cnt_d   = cnt_q;
        off_d   = off_q;
        stall_d = 1'b0;
        q_d     = q_q;
        if (stall_q) begin
            cnt_d = cnt_q;
        end else if (boundary) begin
            cnt_d = 4'd0;
            q_d   = window;
            if (io.BITSLIP) begin
                if ((B == 1) || !off_q) begin
                    stall_d = 1'b1;
                end
                if (B == 2) begin
                    off_d = ~off_q;
                end
            end
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Rising-edge state; everything holds while either clock enable is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q <= '0;
            cnt_q   <= 4'd0;
            off_q   <= 1'b0;
            stall_q <= 1'b0;
            q_q     <= '0;
        end else if (ce) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            stall_q <= stall_d;
            q_q     <= q_d;
        end
    end

    // Outputs above DATA_WIDTH read as zero.
    always_comb begin
        q_ext                 = 8'd0;
        q_ext[DATA_WIDTH-1:0] = q_q;
    end

    assign io.Q1 = q_ext[0];
    assign io.Q2 = q_ext[1];
    assign io.Q3 = q_ext[2];
    assign io.Q4 = q_ext[3];
    assign io.Q5 = q_ext[4];
    assign io.Q6 = q_ext[5];
    assign io.Q7 = q_ext[6];
    assign io.Q8 = q_ext[7];
endmodule

// File: tb/tb_iserdes_e2.sv
// tb/tb_iserdes_e2.sv - directed self-checking bench for iserdes_e2 (DDR x8 and SDR x4)
module tb_iserdes_e2;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic bits_q[$];

    always #5 CLK = ~CLK;

    iserdes_e2_if if_ddr ();
    iserdes_e2_if if_sdr ();

    iserdes_e2 #(.DATA_RATE("DDR"), .DATA_WIDTH(8), .INTERFACE_TYPE("NETWORKING")) u_ddr (
        .CLK(CLK),
        .RST(RST),
        .io (if_ddr)
    );

    iserdes_e2 #(.DATA_RATE("SDR"), .DATA_WIDTH(4), .INTERFACE_TYPE("NETWORKING")) u_sdr (
        .CLK(CLK),
        .RST(RST),
        .io (if_sdr)
    );

    function automatic logic [7:0] ddr_q();
        return {if_ddr.Q8, if_ddr.Q7, if_ddr.Q6, if_ddr.Q5, if_ddr.Q4, if_ddr.Q3, if_ddr.Q2, if_ddr.Q1};
    endfunction

    function automatic logic [7:0] sdr_q();
        return {if_sdr.Q8, if_sdr.Q7, if_sdr.Q6, if_sdr.Q5, if_sdr.Q4, if_sdr.Q3, if_sdr.Q2, if_sdr.Q1};
    endfunction

    task automatic pop_bit(output logic b);
        if (bits_q.size() > 0) b = bits_q.pop_front();
        else b = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    // Entered at rising edge + 1; older bit sampled on the falling edge, newer on the rise.
    task automatic ddr_edge();
        logic a;
        logic b;
        pop_bit(a);
        pop_bit(b);
        if_ddr.D = a;
        @(negedge CLK);
        #2;
        if_ddr.D = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic sdr_edge(input logic b);
        if_sdr.D = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic sdr_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) sdr_edge(w[i]);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        if_ddr.BITSLIP = 1'b0;
        if_sdr.BITSLIP = 1'b0;
        if_ddr.D = 1'b0;
        if_sdr.D = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bits_q.delete();
    endtask

    task automatic test_reset();
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (ddr_q() !== 8'h00) begin n_fail++; $display("FAIL reset_ddr_q got=%h exp=00", ddr_q()); end
        n_checks++;
        if (sdr_q() !== 8'h00) begin n_fail++; $display("FAIL reset_sdr_q got=%h exp=00", sdr_q()); end
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bits_q.delete();
        for (int w = 0; w < 2; w++) begin
            repeat (4) ddr_edge();
            n_checks++;
            if (ddr_q() !== 8'h00) begin n_fail++; $display("FAIL reset_idle_%0d got=%h exp=00", w, ddr_q()); end
        end
        push_byte(8'hFF);
        repeat (4) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'hFF) begin n_fail++; $display("FAIL reset_ff_word got=%h exp=ff", ddr_q()); end
        push_byte(8'hFF);
        repeat (2) ddr_edge();
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (ddr_q() !== 8'h00) begin n_fail++; $display("FAIL reset_mid_word got=%h exp=00", ddr_q()); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bits_q.delete();
        push_byte(8'h81);
        repeat (4) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'h81) begin n_fail++; $display("FAIL reset_restart_word got=%h exp=81", ddr_q()); end
    endtask

    task automatic test_passthrough();
        logic [7:0] pat;
        logic       exp;
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            RST = (i < 4);
            exp = pat[i];
            if_ddr.D = exp;
            if_sdr.D = ~exp;
            #1;
            n_checks++;
            if (if_ddr.O !== exp) begin n_fail++; $display("FAIL pass_ddr_%0d got=%b exp=%b", i, if_ddr.O, exp); end
            n_checks++;
            if (if_sdr.O !== ~exp) begin n_fail++; $display("FAIL pass_sdr_%0d got=%b exp=%b", i, if_sdr.O, ~exp); end
            #4;
        end
    endtask

    task automatic test_ddr_aligned();
        logic [7:0] words [5];
        words = '{8'h01, 8'h01, 8'h01, 8'hA5, 8'h3C};
        do_reset();
        for (int w = 0; w < 5; w++) push_byte(words[w]);
        push_byte(8'h00);
        for (int w = 0; w < 5; w++) begin
            repeat (4) ddr_edge();
            n_checks++;
            if (ddr_q() !== words[w]) begin n_fail++; $display("FAIL ddr_word_%0d got=%h exp=%h", w, ddr_q(), words[w]); end
        end
        repeat (2) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'h3C) begin n_fail++; $display("FAIL ddr_hold_mid_word got=%h exp=3c", ddr_q()); end
    endtask

    task automatic test_bitslip();
        logic [7:0] exp_word;
        int         slips;
        do_reset();
        for (int w = 0; w < 3; w++) push_byte(8'hAA);
        for (int i = 0; i < 3; i++) bits_q.push_back(1'b0);
        for (int w = 0; w < 10; w++) push_byte(8'h01);
        for (int w = 0; w < 3; w++) begin
            repeat (4) ddr_edge();
            n_checks++;
            if (ddr_q() !== 8'hAA) begin n_fail++; $display("FAIL slip_aa_%0d got=%h exp=aa", w, ddr_q()); end
        end
        repeat (4) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'h00) begin n_fail++; $display("FAIL slip_gap_word got=%h exp=00", ddr_q()); end
        repeat (4) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'h20) begin n_fail++; $display("FAIL slip_misaligned got=%h exp=20", ddr_q()); end
        exp_word = 8'h20;
        slips = 0;
        while ((exp_word != 8'h01) && (slips < 8)) begin
            repeat (3) ddr_edge();
            if_ddr.BITSLIP = 1'b1;
            ddr_edge();
            if_ddr.BITSLIP = 1'b0;
            n_checks++;
            if (ddr_q() !== exp_word) begin n_fail++; $display("FAIL slip_edge_word_%0d got=%h exp=%h", slips, ddr_q(), exp_word); end
            slips++;
            repeat (((slips % 2) == 1) ? 5 : 4) ddr_edge();
            exp_word = {exp_word[6:0], exp_word[7]};
            n_checks++;
            if (ddr_q() !== exp_word) begin n_fail++; $display("FAIL slip_rotate_%0d got=%h exp=%h", slips, ddr_q(), exp_word); end
        end
        n_checks++;
        if (slips != 3) begin n_fail++; $display("FAIL slip_count got=%0d exp=3", slips); end
        bits_q.delete();
        for (int i = 0; i < 6; i++) bits_q.push_back(1'b0);
        bits_q.push_back(1'b1);
        for (int v = 1; v <= 200; v++) push_byte(8'(v));
        repeat (4) ddr_edge();
        n_checks++;
        if (ddr_q() !== 8'h01) begin n_fail++; $display("FAIL stream_first got=%h exp=01", ddr_q()); end
        for (int v = 1; v <= 200; v++) begin
            repeat (4) ddr_edge();
            n_checks++;
            if (ddr_q() !== 8'(v)) begin n_fail++; $display("FAIL stream_byte_%0d got=%h exp=%h", v, ddr_q(), 8'(v)); end
        end
    endtask

    task automatic test_sdr();
        do_reset();
        if_sdr.CE1 = 1'b1;
        if_sdr.CE2 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            sdr_word(4'h5);
            n_checks++;
            if (sdr_q() !== 8'h05) begin n_fail++; $display("FAIL sdr_word5_%0d got=%h exp=05", w, sdr_q()); end
        end
        sdr_edge(1'b0);
        sdr_edge(1'b0);
        sdr_edge(1'b1);
        n_checks++;
        if (sdr_q() !== 8'h05) begin n_fail++; $display("FAIL sdr_partial_hold got=%h exp=05", sdr_q()); end
        if_sdr.CE1 = 1'b0;
        if_sdr.BITSLIP = 1'b1;
        if_sdr.D = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        n_checks++;
        if (sdr_q() !== 8'h05) begin n_fail++; $display("FAIL sdr_ce_low_hold got=%h exp=05", sdr_q()); end
        if_sdr.CE1 = 1'b1;
        if_sdr.BITSLIP = 1'b0;
        sdr_edge(1'b1);
        n_checks++;
        if (sdr_q() !== 8'h03) begin n_fail++; $display("FAIL sdr_ce_resume got=%h exp=03", sdr_q()); end
        sdr_word(4'hA);
        n_checks++;
        if (sdr_q() !== 8'h0A) begin n_fail++; $display("FAIL sdr_word_a got=%h exp=0a", sdr_q()); end
        sdr_word(4'h5);
        sdr_edge(1'b0);
        sdr_edge(1'b1);
        sdr_edge(1'b0);
        if_sdr.BITSLIP = 1'b1;
        sdr_edge(1'b1);
        if_sdr.BITSLIP = 1'b0;
        n_checks++;
        if (sdr_q() !== 8'h05) begin n_fail++; $display("FAIL sdr_slip_edge got=%h exp=05", sdr_q()); end
        sdr_word(4'h5);
        n_checks++;
        if (sdr_q() !== 8'h05) begin n_fail++; $display("FAIL sdr_slip_stall got=%h exp=05", sdr_q()); end
        sdr_edge(1'b0);
        n_checks++;
        if (sdr_q() !== 8'h0A) begin n_fail++; $display("FAIL sdr_slip_rotate got=%h exp=0a", sdr_q()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        if_ddr.D = 1'b0;
        if_ddr.DDLY = 1'b0;
        if_ddr.CE1 = 1'b1;
        if_ddr.CE2 = 1'b1;
        if_ddr.BITSLIP = 1'b0;
        if_sdr.D = 1'b0;
        if_sdr.DDLY = 1'b0;
        if_sdr.CE1 = 1'b1;
        if_sdr.CE2 = 1'b1;
        if_sdr.BITSLIP = 1'b0;
        test_reset();
        test_passthrough();
        test_ddr_aligned();
        test_bitslip();
        test_sdr();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
